alu_req_arbiter: RTL

Sequencing and arbitration front-end for the team's 4-bit combinational custom ALU. Two independent requesters submit {opcode, A, B, tag} commands over valid/ready handshakes; the block grants one at a time (round-robin), drives the ALU operand/opcode inputs from registers, captures the packed 8-bit ALU output {Zero, Carry, Sign, Error, Result[3:0]} and returns it to the granted requester with its tag. It also keeps a saturating count of ALU error flags for debug.

---
 rtl/alu_req_arbiter_if.sv | 61 ++++++
 rtl/alu_req_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_req_arbiter_if : requester/response/ALU bundle for alu_req_arbiter
// Revision 1.0
// ============================================================================
interface alu_req_arbiter_if #(
  parameter int TAG_W = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [7:0]       rsp0_data;
  logic [TAG_W-1:0] rsp0_tag;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [7:0]       rsp1_data;
  logic [TAG_W-1:0] rsp1_tag;

  logic [3:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [7:0]       alu_res;

  logic             busy;
  logic [7:0]       err_count;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output rsp0_ready, rsp1_ready, alu_res,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_tag,
    input  rsp1_valid, rsp1_data, rsp1_tag,
    input  alu_op, alu_a, alu_b, busy, err_count
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  rsp0_ready, rsp1_ready, alu_res,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_tag,
    output rsp1_valid, rsp1_data, rsp1_tag,
    output alu_op, alu_a, alu_b, busy, err_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// alu_req_arbiter : round-robin two-requester command front-end for the 4-bit ALU
// Revision 1.0
// ============================================================================
module alu_req_arbiter #(
  parameter int TAG_W = 2
) (
  input  wire              clk,
  input  wire              rst,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [3:0]       op_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       result_q;
  logic [7:0]       err_count_q;

  logic             owner_d;
  logic [7:0]       err_count_d;
  logic             rsp_hs;

  // Requester 1 wins only when alone or when requester 0 was served last.
  always_comb begin
    owner_d = 1'b0;
    if (bus.req1_valid && (!bus.req0_valid || !last_grant_q)) begin
      owner_d = 1'b1;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (bus.alu_res[4] && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  assign rsp_hs = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 4'd0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      tag_q        <= '0;
      result_q     <= 8'd0;
      err_count_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            op_q         <= owner_d ? bus.req1_op  : bus.req0_op;
            a_q          <= owner_d ? bus.req1_a   : bus.req0_a;
            b_q          <= owner_d ? bus.req1_b   : bus.req0_b;
            tag_q        <= owner_d ? bus.req1_tag : bus.req0_tag;
            owner_q      <= owner_d;
            last_grant_q <= owner_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= bus.alu_res;
          err_count_q <= err_count_d;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !owner_d;
  assign bus.req1_ready = (state_q == IDLE) && owner_d;

  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) && owner_q;
  assign bus.rsp0_data  = result_q;
  assign bus.rsp1_data  = result_q;
  assign bus.rsp0_tag   = tag_q;
  assign bus.rsp1_tag   = tag_q;

  // Issue registers double as the ALU drive so the ALU inputs never glitch.
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;

  assign bus.busy       = (state_q != IDLE);
  assign bus.err_count  = err_count_q;

endmodule
`default_nettype wire
